// File: rtl/hazard_tracker_pkg.sv
// hazard_pkg: shared types for the hazard tracker.
//   DEF_REG_ADDR_W : default register index width
//   ZERO_REG       : index of the hard-wired zero register (x0)
//   ex/mem/wb_slot_t: per-stage bookkeeping; the valid bit is the MSB so
//                    the generic slot register can clear it as a bubble.
//   action_t       : per-cycle pipeline action chosen by the priority logic
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [DEF_REG_ADDR_W-1:0] ZERO_REG = {DEF_REG_ADDR_W{1'b0}};

  typedef struct packed {
    logic                      v;
    logic [DEF_REG_ADDR_W-1:0] rs1;
    logic [DEF_REG_ADDR_W-1:0] rs2;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      regwrite;
    logic                      memread;
    logic                      memreq;
  } ex_slot_t;

  typedef struct packed {
    logic                      v;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      regwrite;
    logic                      memreq;
  } mem_slot_t;

  typedef struct packed {
    logic                      v;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      regwrite;
  } wb_slot_t;

  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_MEM_WAIT = 2'd1,
    ACT_FLUSH    = 2'd2,
    ACT_LOAD_USE = 2'd3
  } action_t;

endpackage

// File: rtl/hazard_tracker_if.sv
// hazard_tracker_if: producer side of the forwarding interface.
//   ex_rs1/ex_rs2 : EX-stage sources (0 when EX is empty)
//   mem_rd/mem_wb : MEM destination and its effective write-enable
//   wb_rd/wb_wb   : WB destination and its effective write-enable
//   master        : driven by hazard_tracker
//   slave         : consumed by the forwarding unit
interface hazard_tracker_if #(
  parameter int AW = 5
);
  logic [AW-1:0] ex_rs1;
  logic [AW-1:0] ex_rs2;
  logic [AW-1:0] mem_rd;
  logic          mem_wb;
  logic [AW-1:0] wb_rd;
  logic          wb_wb;

  modport master (
    output ex_rs1, ex_rs2, mem_rd, mem_wb, wb_rd, wb_wb
  );

  modport slave (
    input ex_rs1, ex_rs2, mem_rd, mem_wb, wb_rd, wb_wb
  );
endinterface

// File: rtl/hazard_slot_reg.sv
// hazard_slot_reg: one pipeline-stage bookkeeping register.
//   clk, rst : clock, synchronous active-high reset (clears the slot)
//   hold     : keep current contents (highest priority after reset)
//   bubble   : clear only the valid bit (MSB); other fields are kept
//   load     : capture d
//   d, q     : slot contents, valid bit in bit W-1
module hazard_slot_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // slot state update: reset > hold > bubble > load
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q[W-1] <= 1'b0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: EX/MEM/WB destination bookkeeping and pipeline control
// for a 5-stage RISC-V pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   id_*                : instruction currently in ID
//   ex_branch_taken     : branch/jump resolved taken in EX
//   dmem_ready          : data memory finishes the MEM access this cycle
//   fwd (master)        : forwarding producer signals
//   stall_if/stall_id   : hold PC / IF-ID
//   flush_id            : clear IF-ID
//   bubble_ex           : NOP into ID-EX
//   freeze_mem          : hold ID-EX and EX-MEM, bubble into MEM-WB
//   stall_cnt           : saturating count of stalled/frozen cycles
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memreq,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_ready,
  hazard_tracker_if.master      fwd,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  bubble_ex,
  output logic                  freeze_mem,
  output logic [CNT_W-1:0]      stall_cnt
);

  ex_slot_t  ex_q,  ex_d;
  mem_slot_t mem_q, mem_d;
  wb_slot_t  wb_q,  wb_d;

  logic    mem_wait, load_use, branch;
  action_t action;
  logic    ex_load, ex_hold, ex_bubble;
  logic    mem_load, mem_hold;
  logic    wb_load, wb_bubble;

  // hazard conditions; a load into x0 never needs a stall
  assign mem_wait = mem_q.v & mem_q.memreq & ~dmem_ready;
  assign load_use = ex_q.v & ex_q.memread & (ex_q.rd != ZERO_REG) & id_valid &
                    ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
  assign branch   = ex_branch_taken & ex_q.v;

  // priority selection: memory wait masks branch and load-use so EX
  // re-presents them once the access completes
  always_comb begin
    action = ACT_ADVANCE;
    if (rst) begin
      action = ACT_ADVANCE;
    end else if (mem_wait) begin
      action = ACT_MEM_WAIT;
    end else if (branch) begin
      action = ACT_FLUSH;
    end else if (load_use) begin
      action = ACT_LOAD_USE;
    end else begin
      action = ACT_ADVANCE;
    end
  end

  // control outputs and slot-register controls for the chosen action
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    flush_id   = 1'b0;
    bubble_ex  = 1'b0;
    freeze_mem = 1'b0;
    ex_load    = 1'b0;
    ex_hold    = 1'b0;
    ex_bubble  = 1'b0;
    mem_load   = 1'b0;
    mem_hold   = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    case (action)
      ACT_MEM_WAIT: begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        freeze_mem = 1'b1;
        ex_hold    = 1'b1;
        mem_hold   = 1'b1;
        wb_bubble  = 1'b1;
      end
      ACT_FLUSH: begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        ex_bubble = 1'b1;
        mem_load  = 1'b1;
        wb_load   = 1'b1;
      end
      ACT_LOAD_USE: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        ex_bubble = 1'b1;
        mem_load  = 1'b1;
        wb_load   = 1'b1;
      end
      ACT_ADVANCE: begin
        ex_load  = 1'b1;
        mem_load = 1'b1;
        wb_load  = 1'b1;
      end
      default: begin
        ex_load = 1'b0;
      end
    endcase
  end

  // next-slot contents: each stage takes the one before it
  always_comb begin
    ex_d          = '0;
    ex_d.v        = id_valid;
    ex_d.rs1      = id_rs1;
    ex_d.rs2      = id_rs2;
    ex_d.rd       = id_rd;
    ex_d.regwrite = id_regwrite;
    ex_d.memread  = id_memread;
    ex_d.memreq   = id_memreq;
    mem_d          = '0;
    mem_d.v        = ex_q.v;
    mem_d.rd       = ex_q.rd;
    mem_d.regwrite = ex_q.regwrite;
    mem_d.memreq   = ex_q.memreq;
    wb_d          = '0;
    wb_d.v        = mem_q.v;
    wb_d.rd       = mem_q.rd;
    wb_d.regwrite = mem_q.regwrite;
  end

  hazard_slot_reg #(.W($bits(ex_slot_t))) u_ex_slot (
    .clk(clk), .rst(rst), .load(ex_load), .hold(ex_hold), .bubble(ex_bubble),
    .d(ex_d), .q(ex_q)
  );

  hazard_slot_reg #(.W($bits(mem_slot_t))) u_mem_slot (
    .clk(clk), .rst(rst), .load(mem_load), .hold(mem_hold), .bubble(1'b0),
    .d(mem_d), .q(mem_q)
  );

  hazard_slot_reg #(.W($bits(wb_slot_t))) u_wb_slot (
    .clk(clk), .rst(rst), .load(wb_load), .hold(1'b0), .bubble(wb_bubble),
    .d(wb_d), .q(wb_q)
  );

  // forwarding producers; writes to x0 are never advertised
  assign fwd.ex_rs1 = ex_q.v ? ex_q.rs1 : ZERO_REG;
  assign fwd.ex_rs2 = ex_q.v ? ex_q.rs2 : ZERO_REG;
  assign fwd.mem_rd = mem_q.rd;
  assign fwd.mem_wb = mem_q.v & mem_q.regwrite & (mem_q.rd != ZERO_REG);
  assign fwd.wb_rd  = wb_q.rd;
  assign fwd.wb_wb  = wb_q.v & wb_q.regwrite & (wb_q.rd != ZERO_REG);

  // saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if ((stall_if | freeze_mem) && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed hazard scenarios followed by random traffic,
// every cycle compared against a stage-level model of the pipeline.
// A 4-bit counter is used so saturation is reached quickly.
module tb_hazard_tracker;
  import hazard_pkg::*;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_regwrite, id_memread, id_memreq;
  logic          ex_branch_taken, dmem_ready;
  logic          stall_if, stall_id, flush_id, bubble_ex, freeze_mem;
  logic [CW-1:0] stall_cnt;

  hazard_tracker_if #(.AW(AW)) fwd_bus ();

  hazard_tracker #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memreq(id_memreq), .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
    .fwd(fwd_bus), .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .bubble_ex(bubble_ex), .freeze_mem(freeze_mem), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: one record per stage, instruction-level view
  typedef struct {
    bit v;
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit mr;
    bit mq;
  } stage_t;

  stage_t ex_m, mem_m, wb_m, empty_m;
  int     cnt_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                        input bit rw, input bit mr, input bit mq);
    id_valid    = v;
    id_rs1      = AW'(rs1);
    id_rs2      = AW'(rs2);
    id_rd       = AW'(rd);
    id_regwrite = rw;
    id_memread  = mr;
    id_memreq   = mq;
  endtask

  task automatic idle();
    set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // one clock: compare all outputs with the model, then retire the cycle
  task automatic step();
    bit wait_c, br_c, lu_c;
    bit e_sif, e_sid, e_fid, e_bex, e_frz;
    stage_t id_m;
    @(negedge clk);
    wait_c = mem_m.v && mem_m.mq && !dmem_ready;
    br_c   = ex_m.v && ex_branch_taken;
    lu_c   = ex_m.v && ex_m.mr && (ex_m.rd != 0) && id_valid &&
             (ex_m.rd == int'(id_rs1) || ex_m.rd == int'(id_rs2));
    e_sif = 1'b0; e_sid = 1'b0; e_fid = 1'b0; e_bex = 1'b0; e_frz = 1'b0;
    if (!rst) begin
      if (wait_c) begin
        e_sif = 1'b1; e_sid = 1'b1; e_frz = 1'b1;
      end else if (br_c) begin
        e_fid = 1'b1; e_bex = 1'b1;
      end else if (lu_c) begin
        e_sif = 1'b1; e_sid = 1'b1; e_bex = 1'b1;
      end
    end
    chk("stall_if", stall_if, e_sif);
    chk("stall_id", stall_id, e_sid);
    chk("flush_id", flush_id, e_fid);
    chk("bubble_ex", bubble_ex, e_bex);
    chk("freeze_mem", freeze_mem, e_frz);
    chk("ex_rs1", fwd_bus.ex_rs1, ex_m.v ? ex_m.rs1 : 0);
    chk("ex_rs2", fwd_bus.ex_rs2, ex_m.v ? ex_m.rs2 : 0);
    chk("mem_rd", fwd_bus.mem_rd, mem_m.rd);
    chk("mem_wb", fwd_bus.mem_wb, mem_m.v && mem_m.rw && mem_m.rd != 0);
    chk("wb_rd", fwd_bus.wb_rd, wb_m.rd);
    chk("wb_wb", fwd_bus.wb_wb, wb_m.v && wb_m.rw && wb_m.rd != 0);
    chk("stall_cnt", stall_cnt, cnt_m);
    id_m = '{v: id_valid, rs1: int'(id_rs1), rs2: int'(id_rs2), rd: int'(id_rd),
             rw: id_regwrite, mr: id_memread, mq: id_memreq};
    @(posedge clk);
    #1;
    if (rst) begin
      ex_m = empty_m; mem_m = empty_m; wb_m = empty_m; cnt_m = 0;
    end else begin
      if ((e_sif || e_frz) && cnt_m < CNT_MAX) cnt_m++;
      if (wait_c) begin
        wb_m.v = 1'b0;
      end else begin
        wb_m  = mem_m;
        mem_m = ex_m;
        if (br_c || lu_c) ex_m.v = 1'b0;
        else ex_m = id_m;
      end
    end
  endtask

  initial begin
    empty_m = '{v: 1'b0, rs1: 0, rs2: 0, rd: 0, rw: 1'b0, mr: 1'b0, mq: 1'b0};
    ex_m = empty_m; mem_m = empty_m; wb_m = empty_m; cnt_m = 0;
    rst = 1'b1; ex_branch_taken = 1'b0; dmem_ready = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    chk("rst_ex_rs1", fwd_bus.ex_rs1, 0);
    chk("rst_mem_wb", fwd_bus.mem_wb, 0);
    chk("rst_wb_wb", fwd_bus.wb_wb, 0);
    chk("rst_cnt", stall_cnt, 0);

    // load-use: lw x5 then add x6,x5,x1
    set_id(1'b1, 2, 0, 5, 1'b1, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5, 1, 6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall_if", stall_if, 1);
    chk("lu_stall_id", stall_id, 1);
    chk("lu_bubble_ex", bubble_ex, 1);
    step();
    #1;
    chk("lu_single_bubble", stall_if, 0);
    chk("lu_mem_rd", fwd_bus.mem_rd, 5);
    chk("lu_mem_wb", fwd_bus.mem_wb, 1);
    step();
    chk("lu_ex_rs1", fwd_bus.ex_rs1, 5);
    chk("lu_wb_rd", fwd_bus.wb_rd, 5);
    idle();
    step(); step(); step();

    // memory wait: lw x7 held in MEM for three cycles
    rst = 1'b1; step(); rst = 1'b0;
    set_id(1'b1, 3, 0, 7, 1'b1, 1'b1, 1'b1);
    step();
    set_id(1'b1, 3, 4, 8, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_freeze", freeze_mem, 1);
      chk("mw_wb_wb", fwd_bus.wb_wb, 0);
      chk("mw_mem_rd", fwd_bus.mem_rd, 7);
      chk("mw_ex_rs2", fwd_bus.ex_rs2, 4);
      step();
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw_released", freeze_mem, 0);
    chk("mw_cnt", stall_cnt, 3);
    step(); step(); step();

    // branch flush
    set_id(1'b1, 1, 2, 10, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 11, 12, 13, 1'b1, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_flush", flush_id, 1);
    chk("br_bubble", bubble_ex, 1);
    chk("br_no_stall", stall_if, 0);
    step();
    ex_branch_taken = 1'b0;
    chk("br_ex_rs1", fwd_bus.ex_rs1, 0);
    chk("br_ex_rs2", fwd_bus.ex_rs2, 0);
    chk("br_mem_rd", fwd_bus.mem_rd, 10);

    // branch together with load-use: flush wins
    set_id(1'b1, 0, 0, 9, 1'b1, 1'b1, 1'b1);
    step();
    set_id(1'b1, 9, 9, 14, 1'b1, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    chk("brlu_flush", flush_id, 1);
    chk("brlu_stall_if", stall_if, 0);
    step();
    ex_branch_taken = 1'b0;
    idle();
    step(); step();

    // memory wait together with branch: freeze first, flush after release
    set_id(1'b1, 1, 0, 15, 1'b1, 1'b1, 1'b1);
    step();
    set_id(1'b1, 2, 3, 16, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 4, 5, 17, 1'b1, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    chk("mwbr_freeze", freeze_mem, 1);
    chk("mwbr_no_flush", flush_id, 0);
    chk("mwbr_no_bubble", bubble_ex, 0);
    step();
    dmem_ready = 1'b1;
    #1;
    chk("mwbr_flush_late", flush_id, 1);
    chk("mwbr_unfrozen", freeze_mem, 0);
    step();
    ex_branch_taken = 1'b0;
    idle();
    step();

    // x0: lw x0 then a use of x0
    set_id(1'b1, 1, 0, 0, 1'b1, 1'b1, 1'b1);
    step();
    set_id(1'b1, 0, 0, 18, 1'b1, 1'b0, 1'b0);
    #1;
    chk("x0_no_stall", stall_if, 0);
    chk("x0_no_bubble", bubble_ex, 0);
    step();
    chk("x0_mem_rd", fwd_bus.mem_rd, 0);
    chk("x0_mem_wb", fwd_bus.mem_wb, 0);
    idle();
    step();
    chk("x0_wb_wb", fwd_bus.wb_wb, 0);

    // reset in the second cycle of a memory wait
    set_id(1'b1, 1, 0, 19, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    step();
    dmem_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rstw_freeze", freeze_mem, 0);
    chk("rstw_stall_if", stall_if, 0);
    step();
    rst = 1'b0;
    dmem_ready = 1'b1;
    #1;
    chk("rstw_freeze_after", freeze_mem, 0);
    chk("rstw_mem_rd", fwd_bus.mem_rd, 0);
    chk("rstw_mem_wb", fwd_bus.mem_wb, 0);
    chk("rstw_cnt", stall_cnt, 0);
    set_id(1'b1, 6, 7, 20, 1'b1, 1'b0, 1'b0);
    step();
    chk("rstw_resume", fwd_bus.ex_rs1, 6);

    // random traffic over a small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_id(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      dmem_ready      = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    idle();
    ex_branch_taken = 1'b0;
    dmem_ready = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
